linebuffer_3x3_multi: RTL and testbench
=======================================

LINEBUFFER_3X3_MULTI -- requirements
Module: linebuffer_3x3_multi

Interface
REQ-001 SHALL have parameter CH, default 8: number of parallel feature-map channels sharing one window position.
REQ-002 SHALL have parameter DW, default 8: bits per pixel per channel.
REQ-003 SHALL have parameter MAX_W, default 224: maximum row width; address width AW = clog2(MAX_W+1).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_start, input, 1: single-cycle pulse that latches the configuration and begins a frame.
REQ-007 SHALL have port cfg_width, input, AW: row width in pixels, sampled on cfg_start.
REQ-008 SHALL have port cfg_height, input, 16: row count, sampled on cfg_start.
REQ-009 SHALL have port in_valid, input, 1: in_data holds one pixel position for all channels.
REQ-010 SHALL have port in_data, input, CH*DW: channel k at bits [k*DW +: DW].
REQ-011 SHALL have port out_valid, output, 1: out_win holds a complete 3x3 window.
REQ-012 SHALL have port out_win, output, CH*9*DW: channel k, tap t = r*3+c at bits [(k*9+t)*DW +: DW]; r=0 is the oldest row, c=0 the oldest column.
REQ-013 SHALL have port out_last, output, 1: qualifies the final window of the frame.
REQ-014 SHALL have port busy, output, 1: a frame is in progress.
REQ-015 SHALL have port cfg_err, output, 1: sticky flag for a rejected configuration.

Function
REQ-016 States SHALL be IDLE and RUN; rst forces IDLE.
REQ-017 cfg_start with 3<=cfg_width<=MAX_W and 3<=cfg_height SHALL latch the configuration, zero the row and column counters, clear cfg_err and enter RUN.
REQ-018 cfg_start with out-of-range configuration SHALL set cfg_err, enter IDLE and leave the latched configuration unchanged.
REQ-019 In IDLE, in_valid SHALL be ignored: no counter, memory or output change.
REQ-020 In RUN, each cycle with in_valid=1 SHALL accept one pixel at (row,col), write it to row memory at address col, and advance col; col wraps from width-1 to 0 and increments row.
REQ-021 Cycles with in_valid=0 SHALL not advance counters or corrupt stored rows; the input stream may have arbitrary gaps.
REQ-022 A pixel accepted in cycle t with row>=2 and col>=2 SHALL produce out_valid=1 in cycle t+2 exactly, with out_win holding pixels rows row-2..row by cols col-2..col.
REQ-023 Windows SHALL never straddle a row boundary; col 0 and col 1 of every row SHALL produce no output.
REQ-024 out_valid SHALL be a one-cycle pulse per qualifying pixel; out_win is don't-care when out_valid=0.
REQ-025 out_last SHALL assert with the window of pixel (height-1,width-1); after that pixel the block SHALL return to IDLE, busy=0 in cycle t+1.
REQ-026 cfg_start during RUN SHALL abort the current frame; a pixel with in_valid in the same cycle SHALL be accepted as (0,0) of the new frame; in-flight outputs of the old frame still emerge at their t+2 slot without out_last.
REQ-027 Total window count per frame SHALL be (width-2)*(height-2).
REQ-028 Data SHALL pass unmodified: no arithmetic, sign extension or padding.

Reset
REQ-029 On rst: state IDLE; out_valid, out_last, busy, cfg_err = 0; counters zero; pipeline valid bits cleared.
REQ-030 Row memory contents SHALL not require reset; no output may expose unwritten memory.
REQ-031 rst mid-frame SHALL discard in-flight windows; no out_valid in the two cycles after rst.

Structure
REQ-032 Package linebuffer_pkg SHALL hold default CH/DW/MAX_W, the tap index constants (TAP_R0C0..TAP_R2C2), and the state encoding.
REQ-033 Two row stores SHALL be instances of sub-module lb_row_ram: simple dual-port RAM, depth MAX_W, width CH*DW, one-cycle registered read.
REQ-034 Counters, FSM and 3x3 shift registers SHALL be shared across all channels; no per-channel control.

Verification
REQ-035 CH=2, width=4, height=4, ramp data, in_valid continuous -> 4 windows, first at 2 cycles after pixel (2,2); out_last on the 4th.
REQ-036 Same frame with in_valid toggling 1,0,0,1 pattern -> identical 4 windows in order, each exactly 2 cycles after its pixel.
REQ-037 cfg_width=2, or cfg_width=MAX_W+1 -> cfg_err=1, busy=0, no out_valid for subsequent in_valid.
REQ-038 cfg_start after 7 pixels of width-5 frame, then new width-3 height-3 frame -> exactly 1 window of the new frame with out_last; no out_last from the old frame.
REQ-039 rst asserted one cycle after pixel (2,2) accepted -> no out_valid; all outputs 0.
REQ-040 width=MAX_W, height=3, back-to-back frames -> MAX_W-2 windows per frame, col wrap at MAX_W-1 correct.

Source files
------------

// File: rtl/linebuffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : linebuffer_pkg
//  Description : Shared constants for the multi-channel 3x3 line buffer:
//                default geometry, window tap indices and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package linebuffer_pkg;

    // Default geometry
    localparam int c_DEF_CH    = 8;
    localparam int c_DEF_DW    = 8;
    localparam int c_DEF_MAX_W = 224;

    // Window tap index t = r*3 + c (r=0 oldest row, c=0 oldest column)
    localparam int TAP_R0C0 = 0;
    localparam int TAP_R0C1 = 1;
    localparam int TAP_R0C2 = 2;
    localparam int TAP_R1C0 = 3;
    localparam int TAP_R1C1 = 4;
    localparam int TAP_R1C2 = 5;
    localparam int TAP_R2C0 = 6;
    localparam int TAP_R2C1 = 7;
    localparam int TAP_R2C2 = 8;

    // FSM encoding
    localparam int                 c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lb_row_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lb_row_ram
//  Description : Simple dual-port row store with one-cycle registered read.
//                A read and write to the same address in one cycle returns
//                the previous contents (read-first), which the line buffer
//                relies on to cascade rows.
//  Ports       : clk          - clock
//                we/waddr/wdata - write port
//                re/raddr/rdata - read port (rdata valid the cycle after re)
//  Revision    : 1.0 - initial release
// ============================================================================
module lb_row_ram #(
    parameter int DEPTH = 224,
    parameter int WIDTH = 64,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents are always written before the read that uses them.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/linebuffer_3x3_multi.sv
`default_nettype none
// ============================================================================
//  Module      : linebuffer_3x3_multi
//  Description : Streaming 3x3 window generator for CH parallel channels.
//                One pixel position (all channels) enters per in_valid;
//                a full 3x3 window leaves exactly two cycles later for every
//                pixel with row>=2 and col>=2.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                cfg_start          - latch cfg_width/cfg_height, start frame
//                in_valid, in_data  - pixel stream, channel k at [k*DW +: DW]
//                out_valid, out_win - window, ch k tap t at [(k*9+t)*DW +: DW]
//                out_last           - final window of the frame
//                busy               - frame in progress
//                cfg_err            - sticky rejected-configuration flag
//  Revision    : 1.0 - initial release
// ============================================================================
module linebuffer_3x3_multi
    import linebuffer_pkg::*;
#(
    parameter  int CH    = c_DEF_CH,
    parameter  int DW    = c_DEF_DW,
    parameter  int MAX_W = c_DEF_MAX_W,
    localparam int AW    = $clog2(MAX_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [AW-1:0]        cfg_width,
    input  logic [15:0]          cfg_height,
    input  logic                 in_valid,
    input  logic [CH*DW-1:0]     in_data,
    output logic                 out_valid,
    output logic [CH*9*DW-1:0]   out_win,
    output logic                 out_last,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int              c_PW      = CH * DW;
    localparam logic [AW-1:0]   c_MIN_W   = AW'(3);
    localparam logic [AW-1:0]   c_MAX_W   = AW'(MAX_W);
    localparam logic [AW-1:0]   c_COL_TWO = AW'(2);
    localparam logic [15:0]     c_MIN_H   = 16'd3;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [AW-1:0]        r_width;
    logic [15:0]          r_height;
    logic [AW-1:0]        r_col;
    logic [15:0]          r_row;
    logic                 r_cfg_err;

    logic                 w_cfg_ok;
    logic                 w_run;
    logic                 w_restart;
    logic                 w_accept;
    logic [AW-1:0]        w_acc_col;
    logic [15:0]          w_acc_row;
    logic [AW-1:0]        w_cur_width;
    logic [15:0]          w_cur_height;
    logic                 w_col_end;
    logic                 w_row_end;
    logic                 w_qualify;

    assign w_cfg_ok  = (cfg_width >= c_MIN_W) && (cfg_width <= c_MAX_W) &&
                       (cfg_height >= c_MIN_H);
    assign w_run     = (r_state == c_ST_RUN);
    assign w_restart = cfg_start && w_cfg_ok;

    // A pixel arriving together with a good cfg_start during RUN belongs to
    // the new frame at (0,0); a rejected cfg_start drops it.
    assign w_accept     = in_valid && w_run && (!cfg_start || w_cfg_ok);
    assign w_acc_col    = w_restart ? '0         : r_col;
    assign w_acc_row    = w_restart ? '0         : r_row;
    assign w_cur_width  = w_restart ? cfg_width  : r_width;
    assign w_cur_height = w_restart ? cfg_height : r_height;

    assign w_col_end = (w_acc_col == w_cur_width - 1'b1);
    assign w_row_end = (w_acc_row == w_cur_height - 16'd1);
    assign w_qualify = (w_acc_row >= 16'd2) && (w_acc_col >= c_COL_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_width   <= '0;
            r_height  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (cfg_start) begin
                if (w_cfg_ok) begin
                    r_width   <= cfg_width;
                    r_height  <= cfg_height;
                    r_col     <= '0;
                    r_row     <= '0;
                    r_cfg_err <= 1'b0;
                    r_state   <= c_ST_RUN;
                end else begin
                    r_cfg_err <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            end
            // Counter advance overrides the restart zeroing above when the
            // restart cycle also carries pixel (0,0).
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    if (w_row_end) begin
                        r_row   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_row <= w_acc_row + 16'd1;
                    end
                end else begin
                    r_col <= w_acc_col + 1'b1;
                end
            end
        end
    end

    assign busy    = w_run;
    assign cfg_err = r_cfg_err;

    // ------------------------------------------------------------------
    // Row stores: prev1 holds row-1, prev2 holds row-2. prev2 is refilled
    // one cycle after each accept with the row-1 value just read out of
    // prev1, so the two stores form a column-wise cascade.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_rd_prev1;
    logic [c_PW-1:0] w_rd_prev2;
    logic            r_v1;
    logic            r_q1;
    logic            r_last1;
    logic [c_PW-1:0] r_pix1;
    logic [AW-1:0]   r_col1;

    lb_row_ram #(
        .DEPTH (MAX_W),
        .WIDTH (c_PW),
        .AW    (AW)
    ) u_ram_prev1 (
        .clk   (clk),
        .we    (w_accept),
        .waddr (w_acc_col),
        .wdata (in_data),
        .re    (w_accept),
        .raddr (w_acc_col),
        .rdata (w_rd_prev1)
    );

    lb_row_ram #(
        .DEPTH (MAX_W),
        .WIDTH (c_PW),
        .AW    (AW)
    ) u_ram_prev2 (
        .clk   (clk),
        .we    (r_v1),
        .waddr (r_col1),
        .wdata (w_rd_prev1),
        .re    (w_accept),
        .raddr (w_acc_col),
        .rdata (w_rd_prev2)
    );

    // ------------------------------------------------------------------
    // Window pipeline: stage 1 aligns the pixel with the RAM read data,
    // stage 2 shifts a new column into the 3x3 window.
    // r_win[col][row], col 0 oldest, row 0 oldest.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_win [3][3];
    logic            r_out_valid;
    logic            r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_q1        <= 1'b0;
            r_last1     <= 1'b0;
            r_pix1      <= '0;
            r_col1      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[c][r] <= '0;
                end
            end
        end else begin
            r_v1    <= w_accept;
            r_q1    <= w_qualify;
            r_last1 <= w_col_end && w_row_end;
            if (w_accept) begin
                r_pix1 <= in_data;
                r_col1 <= w_acc_col;
            end

            r_out_valid <= r_v1 && r_q1;
            r_out_last  <= r_v1 && r_q1 && r_last1;

            if (r_v1) begin
                for (int c = 0; c < 2; c++) begin
                    for (int r = 0; r < 3; r++) begin
                        r_win[c][r] <= r_win[c+1][r];
                    end
                end
                r_win[2][0] <= w_rd_prev2;
                r_win[2][1] <= w_rd_prev1;
                r_win[2][2] <= r_pix1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    for (genvar k = 0; k < CH; k++) begin : g_chan
        assign out_win[(k*9+TAP_R0C0)*DW +: DW] = r_win[0][0][k*DW +: DW];
        assign out_win[(k*9+TAP_R0C1)*DW +: DW] = r_win[1][0][k*DW +: DW];
        assign out_win[(k*9+TAP_R0C2)*DW +: DW] = r_win[2][0][k*DW +: DW];
        assign out_win[(k*9+TAP_R1C0)*DW +: DW] = r_win[0][1][k*DW +: DW];
        assign out_win[(k*9+TAP_R1C1)*DW +: DW] = r_win[1][1][k*DW +: DW];
        assign out_win[(k*9+TAP_R1C2)*DW +: DW] = r_win[2][1][k*DW +: DW];
        assign out_win[(k*9+TAP_R2C0)*DW +: DW] = r_win[0][2][k*DW +: DW];
        assign out_win[(k*9+TAP_R2C1)*DW +: DW] = r_win[1][2][k*DW +: DW];
        assign out_win[(k*9+TAP_R2C2)*DW +: DW] = r_win[2][2][k*DW +: DW];
    end

endmodule
`default_nettype wire

// File: tb/tb_linebuffer_3x3_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_linebuffer_3x3_multi
//  Description : Randomised scoreboard bench for linebuffer_3x3_multi.
//                The reference keeps each frame as a 2-D image and cuts the
//                expected 3x3 window straight out of it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_linebuffer_3x3_multi;

    localparam int CH    = 2;
    localparam int DW    = 8;
    localparam int MAX_W = 224;
    localparam int AW    = $clog2(MAX_W + 1);
    localparam int PW    = CH * DW;
    localparam int WW    = CH * 9 * DW;
    localparam int HROWS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_width = '0;
    logic [15:0]   cfg_height = '0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic [WW-1:0] out_win;
    logic          out_last;
    logic          busy;
    logic          cfg_err;

    linebuffer_3x3_multi #(.CH(CH), .DW(DW), .MAX_W(MAX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_win    (out_win),
        .out_last   (out_last),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_edges = 0;
    always @(posedge clk) n_edges <= n_edges + 1;

    typedef struct {
        int            due;
        logic [WW-1:0] win;
        bit            last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_win  = 0;
    int   n_last = 0;

    // Reference model state
    bit   m_run = 0;
    bit   m_err = 0;
    int   m_row = 0;
    int   m_col = 0;
    int   m_w   = 0;
    int   m_h   = 0;
    logic [PW-1:0] img [HROWS][MAX_W];

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (edge %0d)", name, act, exp, n_edges);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] build_win(int row, int col);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < CH; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[(k*9 + r*3 + c)*DW +: DW] = img[(row-2+r) % HROWS][col-2+c][k*DW +: DW];
        return w;
    endfunction

    // Present one cycle of stimulus and update the reference model.
    task automatic step(bit cs, int w, int h, bit v, logic [PW-1:0] d);
        bit   was;
        bit   ok;
        bit   acc;
        exp_t e;
        cfg_start  = cs;
        cfg_width  = AW'(w);
        cfg_height = 16'(h);
        in_valid   = v;
        in_data    = d;
        was = m_run;
        ok  = (w >= 3) && (w <= MAX_W) && (h >= 3);
        acc = v && was;
        if (cs) begin
            if (ok) begin
                m_w = w; m_h = h; m_row = 0; m_col = 0; m_run = 1; m_err = 0;
            end else begin
                m_err = 1; m_run = 0; acc = 0;
            end
        end
        if (acc) begin
            img[m_row % HROWS][m_col] = d;
            if (m_row >= 2 && m_col >= 2) begin
                e.due  = n_edges + 2;
                e.win  = build_win(m_row, m_col);
                e.last = (m_row == m_h - 1) && (m_col == m_w - 1);
                sb.push_back(e);
            end
            m_col++;
            if (m_col == m_w) begin
                m_col = 0;
                m_row++;
                if (m_row == m_h) begin
                    m_row = 0;
                    m_run = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        check_bit("busy", busy, m_run);
        check_bit("cfg_err", cfg_err, m_err);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        // Windows due after this edge are discarded by the reset.
        while (sb.size() > 0 && sb[$].due > n_edges) void'(sb.pop_back());
        m_run = 0; m_err = 0; m_row = 0; m_col = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_last", out_last, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_cfg_err", cfg_err, 1'b0);
        checks++;
        if (out_win !== '0) begin
            errors++;
            $display("FAIL rst_out_win: got %h expected 0", out_win);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(2);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d windows outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // mode 0: continuous, 1: repeating 1,0,0,1 valid pattern, 2: random gaps
    task automatic run_frame(int w, int h, int mode, bit ramp);
        int            p;
        int            i;
        bit            v;
        logic [PW-1:0] d;
        p = 0;
        i = 0;
        step(1, w, h, 0, '0);
        while (p < w * h) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (i % 4 == 0) || (i % 4 == 3);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            for (int k = 0; k < CH; k++)
                d[k*DW +: DW] = ramp ? DW'(p + k * 100) : DW'($urandom);
            step(0, 0, 0, v, d);
            if (v) p++;
            i++;
        end
    endtask

    task automatic clear_counts();
        n_win  = 0;
        n_last = 0;
    endtask

    // Monitor: compares every presented window against the scoreboard.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < n_edges) begin
            checks++;
            errors++;
            $display("FAIL window_missing: expected at edge %0d, still pending at edge %0d",
                     sb[0].due, n_edges);
            void'(sb.pop_front());
        end
        if (out_valid === 1'b1) begin
            n_win++;
            if (out_last === 1'b1) n_last++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL window_spurious: out_valid at edge %0d win=%h, expected no window",
                         n_edges, out_win);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.due != n_edges || mon_e.win !== out_win || mon_e.last !== out_last) begin
                    errors++;
                    $display("FAIL window: got edge %0d win=%h last=%0b, expected edge %0d win=%h last=%0b",
                             n_edges, out_win, out_last, mon_e.due, mon_e.win, mon_e.last);
                end
            end
        end else if (out_last === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL last_without_valid: out_last=1 expected 0 at edge %0d", n_edges);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] d;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 4x4 ramp, continuous
        clear_counts();
        run_frame(4, 4, 0, 1);
        drain();
        check_int("ramp_cont_windows", n_win, 4);
        check_int("ramp_cont_last", n_last, 1);

        // Same frame with 1,0,0,1 valid pattern
        clear_counts();
        run_frame(4, 4, 1, 1);
        drain();
        check_int("ramp_gap_windows", n_win, 4);
        check_int("ramp_gap_last", n_last, 1);

        // Rejected configurations
        clear_counts();
        step(1, 2, 4, 0, '0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, PW'($urandom));
        step(1, MAX_W + 1, 4, 0, '0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, PW'($urandom));
        step(1, 5, 2, 0, '0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, PW'($urandom));
        drain();
        check_int("bad_cfg_windows", n_win, 0);

        // Abort a width-5 frame after 7 pixels with a 3x3 frame
        clear_counts();
        step(1, 5, 5, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, PW'($urandom));
        step(1, 3, 3, 1, PW'($urandom));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, PW'($urandom));
        drain();
        check_int("abort_windows", n_win, 1);
        check_int("abort_last", n_last, 1);

        // Reset one cycle after pixel (2,2)
        clear_counts();
        step(1, 4, 4, 0, '0);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 1, PW'($urandom));
        do_reset();
        idle(4);
        check_int("reset_mid_windows", n_win, 0);

        // Full-width frames back to back
        clear_counts();
        run_frame(MAX_W, 3, 0, 0);
        run_frame(MAX_W, 3, 2, 0);
        drain();
        check_int("maxw_windows", n_win, 2 * (MAX_W - 2));
        check_int("maxw_last", n_last, 2);

        // Random mix of frames, gaps, aborts and bad configurations
        run_frame(6, 4, 2, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1, $urandom_range(1, 12), $urandom_range(2, 6),
                     $urandom_range(0, 1) == 1, PW'($urandom));
            end else begin
                for (int k = 0; k < CH; k++) d[k*DW +: DW] = DW'($urandom);
                step(0, 0, 0, $urandom_range(0, 9) < 7, d);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
